// File: rtl/cache_bus_controller_pkg.sv
// cache_bus_controller_pkg
// Shared types and constants for the two-cache shared-memory bus controller.
// Holds the request field layout, the read/write encodings, the controller
// state encoding and the reset constants used by the controller and its
// bus interface.
package cache_bus_controller_pkg;

    // Request word layout: {rw[24], data[23:16], address[15:0]}
    localparam int REQ_W   = 25;
    localparam int DATA_W  = 8;
    localparam int ADDR_W  = 16;
    localparam int BLOCK_W = 16;

    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;

    // Invalidate outputs idle at all-ones so a reset value is never mistaken
    // for a real line address near zero.
    localparam logic [ADDR_W-1:0] INV_RESET = 16'hFFFF;

    typedef struct packed {
        logic              rw;
        logic [DATA_W-1:0] data;
        logic [ADDR_W-1:0] addr;
    } mem_req_t;

    localparam mem_req_t REQ_NONE = '{rw: RW_READ, data: '0, addr: '0};

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ISSUE   = 3'd1,
        ST_WAIT    = 3'd2,
        ST_RESPOND = 3'd3,
        ST_RELEASE = 3'd4
    } state_t;

    function automatic logic isWrite(input mem_req_t r);
        return r.rw == RW_WRITE;
    endfunction

endpackage

// File: rtl/cache_bus_controller_if.sv
// cache_bus_controller_if
// Bundles every cache-side and memory-side signal of the bus controller.
//   slave  : controller view (takes cache requests and memory responses,
//            drives responses, invalidates, memory requests, timeout flag)
//   master : environment view (caches plus shared memory)
// Signals:
//   req0/req1, req0_ready/req1_ready   cache requests and their valid flags
//   resp0/resp1, resp0_ready/resp1_ready block data back to each cache
//   inv0_address/inv1_address          invalidate address into each cache
//   mem_request, mem_request_ready     request to shared memory
//   mem_response, mem_response_ready   memory block data
//   timeout_error                      one-cycle abort pulse
interface cache_bus_controller_if;
    import cache_bus_controller_pkg::*;

    logic [REQ_W-1:0]   req0;
    logic [REQ_W-1:0]   req1;
    logic               req0_ready;
    logic               req1_ready;
    logic [BLOCK_W-1:0] resp0;
    logic [BLOCK_W-1:0] resp1;
    logic               resp0_ready;
    logic               resp1_ready;
    logic [ADDR_W-1:0]  inv0_address;
    logic [ADDR_W-1:0]  inv1_address;
    logic [REQ_W-1:0]   mem_request;
    logic               mem_request_ready;
    logic [BLOCK_W-1:0] mem_response;
    logic               mem_response_ready;
    logic               timeout_error;

    modport slave (
        input  req0, req1, req0_ready, req1_ready,
        input  mem_response, mem_response_ready,
        output resp0, resp1, resp0_ready, resp1_ready,
        output inv0_address, inv1_address,
        output mem_request, mem_request_ready,
        output timeout_error
    );

    modport master (
        output req0, req1, req0_ready, req1_ready,
        output mem_response, mem_response_ready,
        input  resp0, resp1, resp0_ready, resp1_ready,
        input  inv0_address, inv1_address,
        input  mem_request, mem_request_ready,
        input  timeout_error
    );

endinterface

// File: rtl/cache_bus_controller_rr_arbiter2.sv
// rr_arbiter2
// Two-way round-robin pick, purely combinational.
// Ports:
//   req[1:0]     pending requests (bit N = cache N)
//   last         index granted most recently
//   grant_valid  at least one request pending
//   grant_idx    winning cache index
module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       grant_valid,
    output logic       grant_idx
);

    // A lone requester always wins; on a tie the cache not granted last wins.
    always_comb begin
        grant_valid = |req;
        grant_idx   = 1'b0;
        unique case (req)
            2'b01:   grant_idx = 1'b0;
            2'b10:   grant_idx = 1'b1;
            2'b11:   grant_idx = ~last;
            default: grant_idx = 1'b0;
        endcase
    end

endmodule

// File: rtl/cache_bus_controller.sv
// cache_bus_controller
// Serialises requests from two caches onto one shared memory port.
// Each transaction runs IDLE -> ISSUE -> WAIT -> RESPOND -> RELEASE, or
// IDLE -> ISSUE -> WAIT -> RELEASE when memory fails to answer within
// TIMEOUT_CYCLES cycles of WAIT. Writes publish their address on the other
// cache's invalidate output.
// Ports:
//   clock  system clock, rising edge
//   reset  synchronous, active-low
//   bus    cache_bus_controller_if.slave (all cache and memory signals)
// Parameter:
//   TIMEOUT_CYCLES  WAIT cycles allowed before abort (1..255)
module cache_bus_controller
    import cache_bus_controller_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input logic                   clock,
    input logic                   reset,
    cache_bus_controller_if.slave bus
);

    localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);

    state_t             state_q, state_d;
    logic               lastGrant_q, lastGrant_d;
    logic               grantIdx_q, grantIdx_d;
    mem_req_t           request_q, request_d;
    logic [7:0]         waitCount_q, waitCount_d;
    logic [BLOCK_W-1:0] resp0_q, resp0_d;
    logic [BLOCK_W-1:0] resp1_q, resp1_d;
    logic [ADDR_W-1:0]  inv0_q, inv0_d;
    logic [ADDR_W-1:0]  inv1_q, inv1_d;
    logic               timeoutErr_q, timeoutErr_d;

    logic               arbValid;
    logic               arbIdx;
    mem_req_t           winnerReq;
    logic               memActive;

    rr_arbiter2 u_arbiter (
        .req         ({bus.req1_ready, bus.req0_ready}),
        .last        (lastGrant_q),
        .grant_valid (arbValid),
        .grant_idx   (arbIdx)
    );

    assign winnerReq = arbIdx ? mem_req_t'(bus.req1) : mem_req_t'(bus.req0);

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            lastGrant_q  <= 1'b1;
            grantIdx_q   <= 1'b0;
            request_q    <= REQ_NONE;
            waitCount_q  <= '0;
            resp0_q      <= '0;
            resp1_q      <= '0;
            inv0_q       <= INV_RESET;
            inv1_q       <= INV_RESET;
            timeoutErr_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            lastGrant_q  <= lastGrant_d;
            grantIdx_q   <= grantIdx_d;
            request_q    <= request_d;
            waitCount_q  <= waitCount_d;
            resp0_q      <= resp0_d;
            resp1_q      <= resp1_d;
            inv0_q       <= inv0_d;
            inv1_q       <= inv1_d;
            timeoutErr_q <= timeoutErr_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        lastGrant_d  = lastGrant_q;
        grantIdx_d   = grantIdx_q;
        request_d    = request_q;
        waitCount_d  = waitCount_q;
        resp0_d      = resp0_q;
        resp1_d      = resp1_q;
        inv0_d       = inv0_q;
        inv1_d       = inv1_q;
        timeoutErr_d = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (arbValid) begin
                    grantIdx_d = arbIdx;
                    request_d  = winnerReq;
                    // The invalidate register is loaded on the edge into
                    // ISSUE so the other cache sees it during ISSUE itself.
                    if (isWrite(winnerReq)) begin
                        if (arbIdx) begin
                            inv0_d = winnerReq.addr;
                        end else begin
                            inv1_d = winnerReq.addr;
                        end
                    end
                    state_d = ST_ISSUE;
                end
            end

            ST_ISSUE: begin
                waitCount_d = '0;
                state_d     = ST_WAIT;
            end

            ST_WAIT: begin
                // A response arriving in the last allowed cycle still wins
                // over the timeout.
                if (bus.mem_response_ready) begin
                    if (grantIdx_q) begin
                        resp1_d = bus.mem_response;
                    end else begin
                        resp0_d = bus.mem_response;
                    end
                    state_d = ST_RESPOND;
                end else if (waitCount_q + 8'd1 == TIMEOUT_LIMIT) begin
                    timeoutErr_d = 1'b1;
                    state_d      = ST_RELEASE;
                end else begin
                    waitCount_d = waitCount_q + 8'd1;
                end
            end

            ST_RESPOND: begin
                lastGrant_d = grantIdx_q;
                state_d     = ST_RELEASE;
            end

            ST_RELEASE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign memActive              = (state_q == ST_ISSUE) || (state_q == ST_WAIT);
    assign bus.mem_request_ready  = memActive;
    assign bus.mem_request        = memActive ? request_q : REQ_NONE;
    assign bus.resp0              = resp0_q;
    assign bus.resp1              = resp1_q;
    assign bus.resp0_ready        = (state_q == ST_RESPOND) && !grantIdx_q;
    assign bus.resp1_ready        = (state_q == ST_RESPOND) && grantIdx_q;
    assign bus.inv0_address       = inv0_q;
    assign bus.inv1_address       = inv1_q;
    assign bus.timeout_error      = timeoutErr_q;

endmodule

// File: tb/tb_cache_bus_controller.sv
// tb_cache_bus_controller
// Directed bench for cache_bus_controller built with TIMEOUT_CYCLES = 4.
// Walks reset, a cache0 read, a cache1 write with invalidate, round-robin
// ties, a memory timeout, a spurious memory response and a mid-WAIT reset.
module tb_cache_bus_controller;

    logic clock;
    logic reset;
    int   compared;
    int   mismatched;

    cache_bus_controller_if busIf ();

    cache_bus_controller #(
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (busIf)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=expired expected=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic waitCycle();
        @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input logic r0Rdy, input logic [24:0] r0,
                                 input logic r1Rdy, input logic [24:0] r1,
                                 input logic memRdy, input logic [15:0] memData);
        busIf.req0_ready         = r0Rdy;
        busIf.req0               = r0;
        busIf.req1_ready         = r1Rdy;
        busIf.req1               = r1;
        busIf.mem_response_ready = memRdy;
        busIf.mem_response       = memData;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, " mem_request_ready"}, 32'(busIf.mem_request_ready), 32'h0);
        checkOutput({tag, " mem_request"}, 32'(busIf.mem_request), 32'h0);
        checkOutput({tag, " resp0"}, 32'(busIf.resp0), 32'h0);
        checkOutput({tag, " resp1"}, 32'(busIf.resp1), 32'h0);
        checkOutput({tag, " resp0_ready"}, 32'(busIf.resp0_ready), 32'h0);
        checkOutput({tag, " resp1_ready"}, 32'(busIf.resp1_ready), 32'h0);
        checkOutput({tag, " inv0_address"}, 32'(busIf.inv0_address), 32'hFFFF);
        checkOutput({tag, " inv1_address"}, 32'(busIf.inv1_address), 32'hFFFF);
        checkOutput({tag, " timeout_error"}, 32'(busIf.timeout_error), 32'h0);
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        reset      = 1'b0;
        applyStimulus(1'b0, 25'h0, 1'b0, 25'h0, 1'b0, 16'h0);

        // Reset state
        waitCycle();
        waitCycle();
        checkResetValues("reset");
        reset = 1'b1;
        waitCycle();

        // Cache0 read of 0x1234, memory answers in the third WAIT cycle
        applyStimulus(1'b1, 25'h0001234, 1'b0, 25'h0, 1'b0, 16'h0);
        waitCycle();
        checkOutput("rd0 issue ready", 32'(busIf.mem_request_ready), 32'h1);
        checkOutput("rd0 issue request", 32'(busIf.mem_request), 32'h0001234);
        waitCycle();
        waitCycle();
        waitCycle();
        applyStimulus(1'b1, 25'h0001234, 1'b0, 25'h0, 1'b1, 16'hBEEF);
        checkOutput("rd0 wait ready", 32'(busIf.mem_request_ready), 32'h1);
        checkOutput("rd0 wait no strobe", 32'(busIf.resp0_ready), 32'h0);
        waitCycle();
        applyStimulus(1'b0, 25'h0, 1'b0, 25'h0, 1'b0, 16'h0);
        checkOutput("rd0 resp0", 32'(busIf.resp0), 32'hBEEF);
        checkOutput("rd0 resp0_ready", 32'(busIf.resp0_ready), 32'h1);
        checkOutput("rd0 resp1_ready", 32'(busIf.resp1_ready), 32'h0);
        checkOutput("rd0 respond mem ready", 32'(busIf.mem_request_ready), 32'h0);
        checkOutput("rd0 respond mem request", 32'(busIf.mem_request), 32'h0);
        waitCycle();
        checkOutput("rd0 release strobe", 32'(busIf.resp0_ready), 32'h0);
        checkOutput("rd0 release hold", 32'(busIf.resp0), 32'hBEEF);
        waitCycle();

        // Cache1 write of 0x5A to 0x0A03 invalidates cache0 only
        applyStimulus(1'b0, 25'h0, 1'b1, 25'h15A0A03, 1'b0, 16'h0);
        waitCycle();
        checkOutput("wr1 request", 32'(busIf.mem_request), 32'h15A0A03);
        checkOutput("wr1 inv0", 32'(busIf.inv0_address), 32'h0A03);
        checkOutput("wr1 inv1", 32'(busIf.inv1_address), 32'hFFFF);
        waitCycle();
        applyStimulus(1'b0, 25'h0, 1'b1, 25'h15A0A03, 1'b1, 16'h1111);
        waitCycle();
        applyStimulus(1'b0, 25'h0, 1'b0, 25'h0, 1'b0, 16'h0);
        checkOutput("wr1 resp1", 32'(busIf.resp1), 32'h1111);
        checkOutput("wr1 resp1_ready", 32'(busIf.resp1_ready), 32'h1);
        checkOutput("wr1 resp0_ready", 32'(busIf.resp0_ready), 32'h0);
        checkOutput("wr1 resp0 hold", 32'(busIf.resp0), 32'hBEEF);
        waitCycle();
        waitCycle();

        // Simultaneous requests: cache0 wins after cache1 was served last
        applyStimulus(1'b1, 25'h0000100, 1'b1, 25'h0000200, 1'b0, 16'h0);
        waitCycle();
        checkOutput("tie1 winner", 32'(busIf.mem_request), 32'h0000100);
        waitCycle();
        applyStimulus(1'b1, 25'h0000100, 1'b1, 25'h0000200, 1'b1, 16'hAAAA);
        waitCycle();
        applyStimulus(1'b0, 25'h0, 1'b1, 25'h0000200, 1'b0, 16'h0);
        checkOutput("tie1 resp0_ready", 32'(busIf.resp0_ready), 32'h1);
        checkOutput("tie1 resp0", 32'(busIf.resp0), 32'hAAAA);
        waitCycle();
        checkOutput("tie1 release idle bus", 32'(busIf.mem_request_ready), 32'h0);
        waitCycle();
        checkOutput("tie1 idle bus", 32'(busIf.mem_request_ready), 32'h0);
        waitCycle();
        checkOutput("tie1 loser served", 32'(busIf.mem_request), 32'h0000200);
        waitCycle();
        applyStimulus(1'b0, 25'h0, 1'b1, 25'h0000200, 1'b1, 16'hBBBB);
        waitCycle();
        applyStimulus(1'b0, 25'h0, 1'b0, 25'h0, 1'b0, 16'h0);
        checkOutput("tie1 resp1_ready", 32'(busIf.resp1_ready), 32'h1);
        checkOutput("tie1 resp1", 32'(busIf.resp1), 32'hBBBB);
        waitCycle();
        waitCycle();

        // Second tie: cache0 again
        applyStimulus(1'b1, 25'h0000300, 1'b1, 25'h0000400, 1'b0, 16'h0);
        waitCycle();
        checkOutput("tie2 winner", 32'(busIf.mem_request), 32'h0000300);
        waitCycle();
        applyStimulus(1'b1, 25'h0000300, 1'b1, 25'h0000400, 1'b1, 16'hCCCC);
        waitCycle();
        applyStimulus(1'b0, 25'h0, 1'b1, 25'h0000400, 1'b0, 16'h0);
        checkOutput("tie2 resp0_ready", 32'(busIf.resp0_ready), 32'h1);
        checkOutput("tie2 resp0", 32'(busIf.resp0), 32'hCCCC);
        waitCycle();
        waitCycle();

        // Cache1 request that memory never answers: abort after 4 WAIT cycles
        waitCycle();
        checkOutput("to issue request", 32'(busIf.mem_request), 32'h0000400);
        waitCycle();
        waitCycle();
        waitCycle();
        waitCycle();
        checkOutput("to wait4 no error", 32'(busIf.timeout_error), 32'h0);
        checkOutput("to wait4 ready", 32'(busIf.mem_request_ready), 32'h1);
        waitCycle();
        applyStimulus(1'b0, 25'h0, 1'b0, 25'h0, 1'b0, 16'h0);
        checkOutput("to error pulse", 32'(busIf.timeout_error), 32'h1);
        checkOutput("to ready dropped", 32'(busIf.mem_request_ready), 32'h0);
        checkOutput("to no resp1 strobe", 32'(busIf.resp1_ready), 32'h0);
        checkOutput("to no resp0 strobe", 32'(busIf.resp0_ready), 32'h0);
        waitCycle();
        checkOutput("to pulse ends", 32'(busIf.timeout_error), 32'h0);
        checkOutput("to resp1 hold", 32'(busIf.resp1), 32'hBBBB);

        // Spurious memory response while idle
        applyStimulus(1'b0, 25'h0, 1'b0, 25'h0, 1'b1, 16'hDEAD);
        waitCycle();
        checkOutput("spur resp0_ready", 32'(busIf.resp0_ready), 32'h0);
        checkOutput("spur resp1_ready", 32'(busIf.resp1_ready), 32'h0);
        checkOutput("spur mem ready", 32'(busIf.mem_request_ready), 32'h0);
        checkOutput("spur resp0 hold", 32'(busIf.resp0), 32'hCCCC);
        waitCycle();
        checkOutput("spur still idle", 32'(busIf.mem_request_ready), 32'h0);

        // Cache0 write of 0x77 to 0x00F0, then reset during WAIT
        applyStimulus(1'b1, 25'h17700F0, 1'b0, 25'h0, 1'b0, 16'h0);
        waitCycle();
        checkOutput("rst wr0 inv1", 32'(busIf.inv1_address), 32'h00F0);
        checkOutput("rst wr0 inv0 hold", 32'(busIf.inv0_address), 32'h0A03);
        waitCycle();
        reset = 1'b0;
        waitCycle();
        checkResetValues("midreset");
        reset = 1'b1;
        applyStimulus(1'b0, 25'h0, 1'b0, 25'h0, 1'b1, 16'h9999);
        waitCycle();
        checkOutput("late resp0_ready", 32'(busIf.resp0_ready), 32'h0);
        checkOutput("late resp0", 32'(busIf.resp0), 32'h0);
        checkOutput("late no error", 32'(busIf.timeout_error), 32'h0);
        applyStimulus(1'b0, 25'h0, 1'b0, 25'h0, 1'b0, 16'h0);
        waitCycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
